// File: rtl/mem_bus_pkg.sv
// Shared types for the byte-wide memory bus initiator.
//   state_t        : bus sequencer states
//   MEM_RD_LATENCY : cycles from address presented to read data valid
//   mem_req_t      : latched CPU-side request
package mem_bus_pkg;

    localparam int PKG_ADDR_W     = 16;
    localparam int PKG_DATA_W     = 8;
    localparam int MEM_RD_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        WR0,
        WR1,
        DONE
    } state_t;

    // Field widths follow the package constants; the top-level parameters
    // default to these and must stay equal to them.
    typedef struct packed {
        logic                      write;
        logic                      word;
        logic [PKG_ADDR_W-1:0]     addr;
        logic [2*PKG_DATA_W-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_bus_master.sv
// Initiator side of the byte-wide synchronous memory bus. Turns one CPU
// byte/word load or store into a sequence of single-byte memory cycles.
// Words are little-endian: low byte at A, high byte at A+1 (mod 2^ADDR_W).
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake (ready only in IDLE)
//   req_write, req_word      : store/load, word/byte
//   req_addr, req_wdata      : byte address A, store data
//   rsp_valid, rsp_rdata     : one-cycle completion pulse, load data
//   mem_addr, mem_wr,
//   mem_wdata, mem_rdata     : memory side (read data registered, 1 cycle)
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int                ADDR_W    = PKG_ADDR_W,
    parameter int                DATA_W    = PKG_DATA_W,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_word,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [2*DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t              state, state_nxt;
    mem_req_t            req_q;
    logic [DATA_W-1:0]   rd_lo;
    logic [ADDR_W-1:0]   addr_p1;

    assign addr_p1 = req_q.addr + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_q     <= '0;
            rd_lo     <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                req_q <= '{write: req_write, word: req_word,
                           addr: req_addr, wdata: req_wdata};
            end
            // rsp_rdata only changes on the edge into DONE, so it holds
            // from one completion to the next; the low byte of a word load
            // waits in rd_lo until the high byte arrives.
            unique case (state)
                RD1: begin
                    if (req_q.word) rd_lo <= mem_rdata;
                    else            rsp_rdata <= {{DATA_W{1'b0}}, mem_rdata};
                end
                RD2:     rsp_rdata <= {mem_rdata, rd_lo};
                WR0:     if (!req_q.word) rsp_rdata <= '0;
                WR1:     rsp_rdata <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_addr  = IDLE_ADDR;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = req_write ? WR0 : RD0;
            end
            RD0: begin
                mem_addr  = req_q.addr;
                state_nxt = RD1;
            end
            RD1: begin
                // Data for A arrives now; for a word, present A+1 meanwhile.
                mem_addr  = req_q.word ? addr_p1 : req_q.addr;
                state_nxt = req_q.word ? RD2 : DONE;
            end
            RD2: begin
                mem_addr  = addr_p1;
                state_nxt = DONE;
            end
            WR0: begin
                mem_wr    = 1'b1;
                mem_addr  = req_q.addr;
                mem_wdata = req_q.wdata[DATA_W-1:0];
                state_nxt = req_q.word ? WR1 : DONE;
            end
            WR1: begin
                mem_wr    = 1'b1;
                mem_addr  = addr_p1;
                mem_wdata = req_q.wdata[2*DATA_W-1:DATA_W];
                state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // While reset is held the bus is quiet: nothing written, no
        // response, and the block looks idle.
        if (rst) begin
            req_ready = 1'b1;
            rsp_valid = 1'b0;
            mem_addr  = IDLE_ADDR;
            mem_wr    = 1'b0;
            mem_wdata = '0;
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_word;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_wdata, mem_rdata;

    mem_bus_master #(.ADDR_W(16), .DATA_W(8), .IDLE_ADDR(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_word(req_word),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- memory (environment) ----------------
    logic        poke_en;
    logic [15:0] poke_addr;
    logic [7:0]  poke_data;
    logic [7:0]  mem [0:65535];

    always @(posedge clk) begin
        if (poke_en)      mem[poke_addr] <= poke_data;
        else if (mem_wr)  mem[mem_addr]  <= mem_wdata;
        if (!mem_wr)      mem_rdata      <= mem[mem_addr];
    end

    // ---------------- reference model ----------------
    // Per accepted request, the model lays out the bus timeline the rules
    // dictate: one entry per cycle after accept, the last being the response.
    typedef struct packed {
        logic        ready;
        logic        rsp;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [15:0] rdata;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] last_rsp;
    bit          on = 0;

    function automatic exp_t mk(logic rsp, logic wr, logic [15:0] a,
                                logic [7:0] d, logic [15:0] rd);
        exp_t e;
        e.ready = 1'b0; e.rsp = rsp; e.wr = wr;
        e.addr = a; e.wdata = d; e.rdata = rd;
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        logic [15:0] a, a1;
        if (rst) begin
            q.delete();
            last_rsp = 16'h0;
            on = 1;
        end else if (on) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.wr)  ref_mem[e.addr] = e.wdata;
                if (e.rsp) last_rsp = e.rdata;
            end else if (req_valid) begin
                a  = req_addr;
                a1 = a + 16'd1;
                if (!req_write && req_word) begin
                    q.push_back(mk(0, 0, a,  0, 0));
                    q.push_back(mk(0, 0, a1, 0, 0));
                    q.push_back(mk(0, 0, a1, 0, 0));
                    q.push_back(mk(1, 0, 0,  0, {ref_mem[a1], ref_mem[a]}));
                end else if (!req_write) begin
                    q.push_back(mk(0, 0, a, 0, 0));
                    q.push_back(mk(0, 0, a, 0, 0));
                    q.push_back(mk(1, 0, 0, 0, {8'h00, ref_mem[a]}));
                end else if (req_word) begin
                    q.push_back(mk(0, 1, a,  req_wdata[7:0],  0));
                    q.push_back(mk(0, 1, a1, req_wdata[15:8], 0));
                    q.push_back(mk(1, 0, 0, 0, 0));
                end else begin
                    q.push_back(mk(0, 1, a, req_wdata[7:0], 0));
                    q.push_back(mk(1, 0, 0, 0, 0));
                end
            end
            if (poke_en) ref_mem[poke_addr] = poke_data;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] exp_rd;
        if (on) begin
            if (q.size() > 0) e = q[0];
            else e = '{ready: 1'b1, rsp: 1'b0, wr: 1'b0, addr: 16'h0,
                       wdata: 8'h0, rdata: 16'h0};
            exp_rd = e.rsp ? e.rdata : last_rsp;
            if (rst) e = '{ready: 1'b1, rsp: 1'b0, wr: 1'b0, addr: 16'h0,
                           wdata: 8'h0, rdata: 16'h0};
            checks++;
            if (req_ready !== e.ready || rsp_valid !== e.rsp || mem_wr !== e.wr ||
                mem_addr !== e.addr || mem_wdata !== e.wdata || rsp_rdata !== exp_rd) begin
                failures++;
                $display("FAIL cycle_model t=%0t got rdy=%b rsp=%b wr=%b addr=%h wd=%h rd=%h exp rdy=%b rsp=%b wr=%b addr=%h wd=%h rd=%h",
                         $time, req_ready, rsp_valid, mem_wr, mem_addr, mem_wdata, rsp_rdata,
                         e.ready, e.rsp, e.wr, e.addr, e.wdata, exp_rd);
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic [15:0] alog [0:7];
    logic [7:0]  dlog [0:7];
    logic        wlog [0:7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    // Issue one request from IDLE; returns load data and the cycle index
    // (accept edge ends cycle 0) in which rsp_valid was seen.
    task automatic do_req(input logic w, input logic wd, input logic [15:0] a,
                          input logic [15:0] d, output logic [15:0] rd, output int lat);
        int n;
        n = 0;
        req_valid = 1'b1; req_write = w; req_word = wd; req_addr = a; req_wdata = d;
        while (!req_ready && n < 20) begin tick(); n++; end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout addr=%h", a);
        end
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom); req_word = 1'($urandom);
        req_addr = 16'($urandom); req_wdata = 16'($urandom);
        for (int i = 0; i < 8; i++) begin alog[i] = '0; dlog[i] = '0; wlog[i] = 1'b0; end
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            if (lat < 8) begin alog[lat] = mem_addr; dlog[lat] = mem_wdata; wlog[lat] = mem_wr; end
            tick();
            lat++;
        end
        rd = rsp_rdata;
        if (!rsp_valid) begin
            checks++; failures++;
            $display("FAIL rsp_timeout addr=%h", a);
        end
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] rd;
        int lat;
        logic [9:0] rdy_v, rsp_v;
        int n_rsp;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
        req_addr = '0; req_wdata = '0; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_ready", {31'b0, req_ready}, 1);
        chk("reset_wr",    {31'b0, mem_wr}, 0);
        chk("reset_rsp",   {31'b0, rsp_valid}, 0);
        chk("reset_addr",  {16'b0, mem_addr}, 32'h0);
        chk("reset_rdata", {16'b0, rsp_rdata}, 32'h0);

        poke(16'h0010, 8'h34); poke(16'h0011, 8'h12); poke(16'h0005, 8'hA7);
        poke(16'hFFFF, 8'h11); poke(16'h0000, 8'h22);
        poke(16'h0200, 8'h00); poke(16'h0201, 8'h00);
        for (int i = 0; i <= 32; i++) poke(16'h0100 + 16'(i), 8'($urandom));

        // word load
        do_req(0, 1, 16'h0010, 16'h0, rd, lat);
        chk("wload_lat", lat, 4);
        chk("wload_data", {16'b0, rd}, 32'h1234);
        chk("wload_a1", {16'b0, alog[1]}, 32'h0010);
        chk("wload_a2", {16'b0, alog[2]}, 32'h0011);
        chk("wload_a3", {16'b0, alog[3]}, 32'h0011);

        // byte load
        do_req(0, 0, 16'h0005, 16'h0, rd, lat);
        chk("bload_lat", lat, 3);
        chk("bload_data", {16'b0, rd}, 32'h00A7);
        chk("bload_nowr", {30'b0, wlog[1], wlog[2]}, 0);

        // word store across a 256-byte boundary, then read back
        do_req(1, 1, 16'h1FFF, 16'hBEEF, rd, lat);
        chk("wstore_lat", lat, 3);
        chk("wstore_c1", {wlog[1], 7'b0, alog[1], dlog[1]}, {1'b1, 7'b0, 16'h1FFF, 8'hEF});
        chk("wstore_c2", {wlog[2], 7'b0, alog[2], dlog[2]}, {1'b1, 7'b0, 16'h2000, 8'hBE});
        chk("wstore_rdata", {16'b0, rd}, 0);
        do_req(0, 1, 16'h1FFF, 16'h0, rd, lat);
        chk("wstore_readback", {16'b0, rd}, 32'hBEEF);

        // word load wrapping past the top of memory
        do_req(0, 1, 16'hFFFF, 16'h0, rd, lat);
        chk("wrap_a2", {16'b0, alog[2]}, 32'h0000);
        chk("wrap_data", {16'b0, rd}, 32'h2211);

        // byte store ignores the upper data byte
        do_req(1, 0, 16'h0030, 16'hFF5A, rd, lat);
        chk("bstore_lat", lat, 2);
        do_req(0, 0, 16'h0030, 16'h0, rd, lat);
        chk("bstore_readback", {16'b0, rd}, 32'h005A);

        // req_valid held high over two word loads
        req_valid = 1'b1; req_write = 1'b0; req_word = 1'b1; req_addr = 16'h0010;
        rdy_v = '0; rsp_v = '0;
        for (int k = 0; k < 10; k++) begin
            rdy_v[k] = req_ready; rsp_v[k] = rsp_valid;
            tick();
        end
        req_valid = 1'b0;
        n_rsp = 0;
        for (int k = 0; k < 10; k++) n_rsp += int'(rsp_v[k]);
        chk("b2b_ready", {22'b0, rdy_v}, 32'b0000100001);
        chk("b2b_rsp_pulses", n_rsp, 2);
        tick();

        // reset during the first byte of a word store
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1;
        req_addr = 16'h0200; req_wdata = 16'hCAFE;
        tick();
        req_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_ready", {31'b0, req_ready}, 1);
        chk("rstmid_wr", {31'b0, mem_wr}, 0);
        n_rsp = 0;
        for (int k = 0; k < 6; k++) begin n_rsp += int'(rsp_valid); tick(); end
        chk("rstmid_no_rsp", n_rsp, 0);
        do_req(0, 1, 16'h0200, 16'h0, rd, lat);
        chk("rstmid_no_hi_write", {24'b0, rd[15:8]}, 0);

        // randomized traffic in a pre-filled window
        for (int t = 0; t < 60; t++) begin
            logic w, wd;
            int gap;
            w = 1'($urandom); wd = 1'($urandom);
            do_req(w, wd, 16'h0100 + 16'($urandom_range(0, 31)), 16'($urandom), rd, lat);
            chk("rand_lat", lat, w ? (wd ? 3 : 2) : (wd ? 4 : 3));
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
